// File: rtl/disp_pkg.sv
// Shared register map, CTRL bit positions and timing-set type for the display timing engine.
package disp_pkg;

    // Register write addresses
    localparam logic [2:0] ADDR_HB   = 3'd0;
    localparam logic [2:0] ADDR_VB   = 3'd1;
    localparam logic [2:0] ADDR_AIP  = 3'd2;
    localparam logic [2:0] ADDR_AIL  = 3'd3;
    localparam logic [2:0] ADDR_CTRL = 3'd4;

    // CTRL register bit indices
    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_SINGLE = 1;
    localparam int unsigned CTRL_CLR_UR = 2;

    // Storage width of one timing value; CNT_W of the engine must not exceed this.
    localparam int unsigned TMG_MAX_W = 16;

    typedef logic [TMG_MAX_W-1:0] tmg_val_t;

    typedef struct packed {
        tmg_val_t hb;
        tmg_val_t vb;
        tmg_val_t aip;
        tmg_val_t ail;
    } timing_t;

    // Zero active pixels or lines would give an empty raster, so they load as 1.
    function automatic timing_t coerce_timing(timing_t t);
        timing_t r;
        r = t;
        if (r.aip == '0) r.aip = tmg_val_t'(1);
        if (r.ail == '0) r.ail = tmg_val_t'(1);
        return r;
    endfunction

endpackage

// File: rtl/disp_wrap_counter.sv
// Loadable modulo counter: counts 0..max_i, flags the wrap cycle, synchronous reset.
module disp_wrap_counter #(
    parameter int unsigned W = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = en_i & (cnt_q == max_i);
    assign cnt_o  = cnt_q;

    // Load has priority over counting; the terminal value folds back to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + W'(1);
        end
    end

    // Counter state register
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/disp_timing_engine.sv
// Display timing engine: staged/shadowed timing registers, raster counters, registered
// blanking/data-enable strobes and a ready/valid pixel gate with sticky underrun.
module disp_timing_engine
    import disp_pkg::*;
#(
    parameter int unsigned CNT_W  = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PIX_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CSDisplay,
    input  logic [2:0]        WAddr,
    input  logic [DATA_W-1:0] WData,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic [CNT_W-1:0]  HBOut_PD,
    output logic [CNT_W-1:0]  VBOut_PD,
    output logic [CNT_W-1:0]  AIPOut_PD,
    output logic [CNT_W-1:0]  AILOut_PD,
    output logic              hblank,
    output logic              vblank,
    output logic              de,
    output logic [PIX_W-1:0]  pix_out,
    output logic              frame_start,
    output logic              underrun
);

    localparam logic [CNT_W:0] CntOne = (CNT_W+1)'(1);

    timing_t stg_q, stg_d;
    timing_t sh_q, sh_d;
    logic    en_q, en_d;
    logic    single_q, single_d;

    logic             hblank_q, hblank_d;
    logic             vblank_q, vblank_d;
    logic             de_q, de_d;
    logic [PIX_W-1:0] pix_out_q, pix_out_d;
    logic             frame_start_q, frame_start_d;
    logic             underrun_q, underrun_d;

    logic [CNT_W-1:0] hb_w, vb_w, aip_w, ail_w;
    logic [CNT_W:0]   h_cnt, v_cnt, h_max, v_max;
    logic             h_wrap, v_wrap, frame_wrap, active, ctrl_wr, cnt_load;

    // Upper WData bits and upper shadow storage bits are intentionally ignored.
    logic unused_wdata, unused_sh;
    assign unused_wdata = ^WData;
    assign unused_sh    = ^sh_q;

    assign hb_w  = sh_q.hb[CNT_W-1:0];
    assign vb_w  = sh_q.vb[CNT_W-1:0];
    assign aip_w = sh_q.aip[CNT_W-1:0];
    assign ail_w = sh_q.ail[CNT_W-1:0];

    // Totals are one bit wider so AIP+HB at their maxima cannot overflow.
    assign h_max = {1'b0, aip_w} + {1'b0, hb_w} - CntOne;
    assign v_max = {1'b0, ail_w} + {1'b0, vb_w} - CntOne;

    assign ctrl_wr    = CSDisplay & (WAddr == ADDR_CTRL);
    assign frame_wrap = v_wrap;
    assign active     = (h_cnt < {1'b0, aip_w}) & (v_cnt < {1'b0, ail_w});
    assign pix_ready  = en_q & active;
    // Counters sit at 0 whenever the engine is (or is about to be) disabled.
    assign cnt_load   = ~en_d;

    disp_wrap_counter #(
        .W (CNT_W+1)
    ) u_h_cnt (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (cnt_load),
        .load_val_i ('0),
        .en_i       (en_q),
        .max_i      (h_max),
        .cnt_o      (h_cnt),
        .wrap_o     (h_wrap)
    );

    disp_wrap_counter #(
        .W (CNT_W+1)
    ) u_v_cnt (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (cnt_load),
        .load_val_i ('0),
        .en_i       (h_wrap),
        .max_i      (v_max),
        .cnt_o      (v_cnt),
        .wrap_o     (v_wrap)
    );

    // Register writes, enable control and frame-synchronous shadow loading
    always_comb begin
        en_d     = en_q;
        single_d = single_q;
        stg_d    = stg_q;
        sh_d     = sh_q;

        if (ctrl_wr) begin
            en_d     = WData[CTRL_EN];
            single_d = WData[CTRL_SINGLE];
        end else if (frame_wrap & single_q) begin
            en_d = 1'b0;
        end

        if (CSDisplay) begin
            case (WAddr)
                ADDR_HB:  stg_d.hb  = tmg_val_t'(WData[CNT_W-1:0]);
                ADDR_VB:  stg_d.vb  = tmg_val_t'(WData[CNT_W-1:0]);
                ADDR_AIP: stg_d.aip = tmg_val_t'(WData[CNT_W-1:0]);
                ADDR_AIL: stg_d.ail = tmg_val_t'(WData[CNT_W-1:0]);
                default:  ;
            endcase
        end

        // Loads the pre-edge staging value, so a same-cycle write waits one frame.
        if ((~en_q & en_d) | frame_wrap) begin
            sh_d = coerce_timing(stg_q);
        end
    end

    // Output stage: strobes and pixel for the current counter position
    always_comb begin
        hblank_d      = en_q & (h_cnt >= {1'b0, aip_w});
        vblank_d      = en_q & (v_cnt >= {1'b0, ail_w});
        de_d          = pix_ready;
        pix_out_d     = (pix_ready & pix_valid) ? pix_data : '0;
        frame_start_d = en_q & (h_cnt == '0) & (v_cnt == '0);
        underrun_d    = underrun_q;
        if (pix_ready & ~pix_valid) begin
            underrun_d = 1'b1;
        end else if (ctrl_wr & WData[CTRL_CLR_UR]) begin
            underrun_d = 1'b0;
        end
    end

    // All state registers; reset overrides any same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_q         <= '0;
            sh_q          <= '0;
            en_q          <= 1'b0;
            single_q      <= 1'b0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            de_q          <= 1'b0;
            pix_out_q     <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            stg_q         <= stg_d;
            sh_q          <= sh_d;
            en_q          <= en_d;
            single_q      <= single_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            de_q          <= de_d;
            pix_out_q     <= pix_out_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign HBOut_PD    = hb_w;
    assign VBOut_PD    = vb_w;
    assign AIPOut_PD   = aip_w;
    assign AILOut_PD   = ail_w;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign de          = de_q;
    assign pix_out     = pix_out_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_disp_timing_engine.sv
// Scoreboard bench: the driver runs a frame-position reference model and queues the expected
// post-edge outputs; a monitor pops and compares one entry after every rising edge.
module tb_disp_timing_engine;

    localparam int unsigned CW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 24;
    localparam logic [31:0] MASK = (32'd1 << CW) - 32'd1;

    logic          clk;
    logic          reset;
    logic          CSDisplay;
    logic [2:0]    WAddr;
    logic [DW-1:0] WData;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          pix_ready;
    logic [CW-1:0] HBOut_PD, VBOut_PD, AIPOut_PD, AILOut_PD;
    logic          hblank, vblank, de, frame_start, underrun;
    logic [PW-1:0] pix_out;

    disp_timing_engine #(
        .CNT_W  (CW),
        .DATA_W (DW),
        .PIX_W  (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .CSDisplay   (CSDisplay),
        .WAddr       (WAddr),
        .WData       (WData),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .HBOut_PD    (HBOut_PD),
        .VBOut_PD    (VBOut_PD),
        .AIPOut_PD   (AIPOut_PD),
        .AILOut_PD   (AILOut_PD),
        .hblank      (hblank),
        .vblank      (vblank),
        .de          (de),
        .pix_out     (pix_out),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    typedef struct packed {
        logic          rdy;
        logic          hbl;
        logic          vbl;
        logic          de;
        logic          fs;
        logic          ur;
        logic [PW-1:0] pix;
        logic [CW-1:0] hb;
        logic [CW-1:0] vb;
        logic [CW-1:0] aip;
        logic [CW-1:0] ail;
    } obs_t;

    obs_t  exp_q[$];
    int    n_total = 0;
    int    n_bad   = 0;
    int    n_cyc   = 0;
    string phase   = "init";

    // Reference model state: timing sets indexed HB, VB, AIP, AIL; k = cycle within frame.
    int stg[4];
    int sh[4];
    int k, m_en, m_single, m_ur, seq;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one expected entry per rising edge, checked 1 time unit after it.
    always @(posedge clk) begin
        obs_t e, g;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {pix_ready, hblank, vblank, de, frame_start, underrun, pix_out,
                 HBOut_PD, VBOut_PD, AIPOut_PD, AILOut_PD};
            n_total++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL %s cyc=%0d got rdy/hb/vb/de/fs/ur=%b%b%b%b%b%b pix=%h pd=%h exp %b%b%b%b%b%b pix=%h pd=%h",
                         phase, n_cyc, g.rdy, g.hbl, g.vbl, g.de, g.fs, g.ur, g.pix,
                         {g.hb, g.vb, g.aip, g.ail}, e.rdy, e.hbl, e.vbl, e.de, e.fs, e.ur,
                         e.pix, {e.hb, e.vb, e.aip, e.ail});
            end
        end
    end

    // Drive one cycle of inputs, advance the model across the edge, queue expectations.
    task automatic cyc(input bit r, input bit cs, input int addr, input logic [31:0] wd,
                       input bit pv);
        obs_t          e;
        int            htot, vtot, h, v;
        bit            act, fend, ctrl, new_en;
        logic [PW-1:0] pd;
        pd        = pv ? seq[PW-1:0] : PW'($urandom);
        reset     = r;
        CSDisplay = cs;
        WAddr     = 3'(addr);
        WData     = wd;
        pix_valid = pv;
        pix_data  = pd;
        e         = '0;
        if (r) begin
            m_en = 0; m_single = 0; m_ur = 0; k = 0;
            for (int i = 0; i < 4; i++) begin
                stg[i] = 0;
                sh[i]  = 0;
            end
        end else begin
            htot = sh[2] + sh[0];
            vtot = sh[3] + sh[1];
            h    = (m_en != 0) ? k % htot : 0;
            v    = (m_en != 0) ? k / htot : 0;
            act  = (m_en != 0) && h < sh[2] && v < sh[3];
            e.de  = act;
            e.hbl = (m_en != 0) && h >= sh[2];
            e.vbl = (m_en != 0) && v >= sh[3];
            e.fs  = (m_en != 0) && k == 0;
            e.pix = (act && pv) ? pd : '0;
            if (act && pv) seq++;
            fend = (m_en != 0) && k == htot * vtot - 1;
            ctrl = cs && addr == 4;
            if (act && !pv) m_ur = 1;
            else if (ctrl && wd[2]) m_ur = 0;
            new_en = (m_en != 0);
            if (ctrl) begin
                new_en   = wd[0];
                m_single = wd[1];
            end else if (fend && m_single != 0) begin
                new_en = 0;
            end
            if ((m_en == 0 && new_en) || fend) begin
                for (int i = 0; i < 4; i++) sh[i] = (i >= 2 && stg[i] == 0) ? 1 : stg[i];
            end
            if (cs && addr < 4) stg[addr] = int'(wd & MASK);
            if (!new_en)          k = 0;
            else if (m_en == 0)   k = 0;
            else if (fend)        k = 0;
            else                  k = k + 1;
            m_en = new_en ? 1 : 0;
        end
        e.ur  = (m_ur != 0);
        e.hb  = CW'(sh[0]);
        e.vb  = CW'(sh[1]);
        e.aip = CW'(sh[2]);
        e.ail = CW'(sh[3]);
        if (m_en != 0) begin
            htot  = sh[2] + sh[0];
            e.rdy = (k % htot) < sh[2] && (k / htot) < sh[3];
        end
        exp_q.push_back(e);
        n_cyc++;
        @(negedge clk);
    endtask

    // Register write with random junk in the bits the block must ignore.
    task automatic wr(input int addr, input int data);
        logic [31:0] keep;
        keep = (addr == 4) ? 32'h7 : MASK;
        cyc(0, 1, addr, ($urandom & ~keep) | (32'(data) & keep), 1);
    endtask

    task automatic run(input int n, input int drop_pct);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, $urandom_range(99, 0) >= drop_pct);
    endtask

    initial begin
        seq = 1;
        phase = "reset";
        repeat (3) cyc(1, 0, 0, 0, 0);
        phase = "idle";
        run(10, 0);

        phase = "continuous";
        wr(0, 2); wr(1, 1); wr(2, 4); wr(3, 3); wr(4, 1);
        run(60, 0);

        phase = "underrun";
        run(60, 20);
        wr(4, 5);
        run(10, 0);

        phase = "frame_sync";
        run(7, 0);
        wr(2, 2);
        run(50, 0);

        phase = "single";
        wr(4, 0);
        run(3, 0);
        wr(4, 3);
        run(40, 0);

        phase = "aip_zero";
        wr(2, 0); wr(3, 2); wr(0, 1); wr(1, 1); wr(4, 1);
        run(20, 0);
        wr(4, 0);

        phase = "max_vals";
        wr(0, 15); wr(2, 15); wr(1, 1); wr(3, 2); wr(4, 1);
        run(100, 5);
        wr(4, 0);

        phase = "random";
        wr(0, 1); wr(1, 0); wr(2, 3); wr(3, 2); wr(4, 1);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(99, 0) < 8) begin
                int a;
                a = $urandom_range(7, 0);
                if (a == 4) wr(4, ($urandom_range(3, 0) != 0) ? ($urandom | 1) : $urandom);
                else        wr(a, ($urandom_range(3, 0) == 0) ? $urandom : $urandom_range(5, 0));
            end else begin
                cyc(0, 0, 0, 0, $urandom_range(99, 0) >= 10);
            end
        end

        phase = "reset_mid";
        wr(4, 0);
        wr(0, 2); wr(1, 1); wr(2, 4); wr(3, 3); wr(4, 1);
        run(9, 0);
        cyc(1, 1, 4, 32'h1, 1);
        run(5, 0);

        phase = "drain";
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
